// File: rtl/rename_map_unit.sv
`timescale 1ns/1ps
// rename_map_unit: speculative + committed register alias tables with a circular physical free list.
// Latency: lookups, phys_rd, old_phys_rd and issue_ready are combinational; all state updates on the next rising edge.
// Backpressure: issue_ready drops when the free list is empty and the request allocates, and during a flush.
//
// Ports:
//   clk, reset                           clock and asynchronous active-high reset
//   issue_valid/issue_ready              decode handshake; rd/rs1/rs2/rd_we describe the instruction
//   phys_rs1, phys_rs2                   speculative source mappings
//   phys_rd, old_phys_rd, alloc          new destination, previous mapping, allocation strobe
//   retire_*                             ROB commit; returns retire_old_phys to the free list
//   flush                                restores spec RAT and free-list head from committed state
//   free_count                           registered number of free physical registers
//
// Optional feature macro RENAME_BUSY_EN adds per-phys ready bits and
// ports wb_valid, wb_phys, rs1_ready, rs2_ready.
module rename_map_unit #(
  parameter int  ARCH_REGS = 32,
  parameter int  PHYS_REGS = 64,
  localparam int AW        = $clog2(ARCH_REGS),
  localparam int PW        = $clog2(PHYS_REGS),
  localparam int FL_DEPTH  = PHYS_REGS - ARCH_REGS,
  localparam int CW        = $clog2(FL_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          issue_valid,
  output logic          issue_ready,
  input  logic [AW-1:0] rd,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  input  logic          rd_we,
  output logic [PW-1:0] phys_rs1,
  output logic [PW-1:0] phys_rs2,
  output logic [PW-1:0] phys_rd,
  output logic [PW-1:0] old_phys_rd,
  output logic          alloc,
  input  logic          retire_valid,
  input  logic          retire_we,
  input  logic [AW-1:0] retire_rd,
  input  logic [PW-1:0] retire_phys_rd,
  input  logic [PW-1:0] retire_old_phys,
  input  logic          flush,
`ifdef RENAME_BUSY_EN
  input  logic          wb_valid,
  input  logic [PW-1:0] wb_phys,
  output logic          rs1_ready,
  output logic          rs2_ready,
`endif
  output logic [CW-1:0] free_count
);

  localparam int FLW = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;

  // Wrap bit distinguishes a full list from an empty one when indices match.
  typedef struct packed {
    logic           wrap;
    logic [FLW-1:0] idx;
  } ptr_t;

  function automatic ptr_t ptr_inc(input ptr_t p);
    ptr_t r;
    if (p.idx == FLW'(FL_DEPTH - 1)) begin
      r.idx  = '0;
      r.wrap = ~p.wrap;
    end else begin
      r.idx  = p.idx + FLW'(1);
      r.wrap = p.wrap;
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] ptr_dist(input ptr_t t, input ptr_t h);
    int d;
    if (t.idx == h.idx) return (t.wrap != h.wrap) ? CW'(FL_DEPTH) : '0;
    d = int'(t.idx) - int'(h.idx);
    if (d < 0) d = d + FL_DEPTH;
    return CW'(d);
  endfunction

  logic [PW-1:0] spec_rat_q [ARCH_REGS];
  logic [PW-1:0] spec_rat_d [ARCH_REGS];
  logic [PW-1:0] comm_rat_q [ARCH_REGS];
  logic [PW-1:0] comm_rat_d [ARCH_REGS];
  logic [PW-1:0] fl_q       [FL_DEPTH];
  logic [PW-1:0] fl_d       [FL_DEPTH];
  ptr_t          head_q, head_d, chead_q, chead_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic needs_alloc, fire, retire_eff;

  always_comb begin
    needs_alloc = rd_we && (rd != '0);
    issue_ready = !flush && ((count_q != '0) || !needs_alloc);
    fire        = issue_valid && issue_ready;
    alloc       = fire && needs_alloc;
    retire_eff  = retire_valid && retire_we && (retire_rd != '0);
    // Arch reg 0 is never written, so its entry stays 0 in both tables.
    phys_rs1    = spec_rat_q[rs1];
    phys_rs2    = spec_rat_q[rs2];
    phys_rd     = needs_alloc ? fl_q[head_q.idx] : '0;
    old_phys_rd = needs_alloc ? spec_rat_q[rd]   : '0;
    free_count  = count_q;
  end

  always_comb begin
    spec_rat_d = spec_rat_q;
    comm_rat_d = comm_rat_q;
    fl_d       = fl_q;
    head_d     = head_q;
    chead_d    = chead_q;
    tail_d     = tail_q;
    count_d    = count_q;

    if (retire_eff) begin
      fl_d[tail_q.idx]      = retire_old_phys;
      tail_d                = ptr_inc(tail_q);
      chead_d               = ptr_inc(chead_q);
      comm_rat_d[retire_rd] = retire_phys_rd;
    end

    if (flush) begin
      // Restore from post-retire committed state so a same-cycle commit is kept.
      spec_rat_d = comm_rat_d;
      head_d     = chead_d;
      count_d    = ptr_dist(tail_d, chead_d);
    end else begin
      if (alloc) begin
        spec_rat_d[rd] = fl_q[head_q.idx];
        head_d         = ptr_inc(head_q);
      end
      case ({alloc, retire_eff})
        2'b10:   count_d = count_q - CW'(1);
        2'b01:   count_d = count_q + CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        spec_rat_q[i] <= PW'(i);
        comm_rat_q[i] <= PW'(i);
      end
      for (int i = 0; i < FL_DEPTH; i++) begin
        fl_q[i] <= PW'(ARCH_REGS + i);
      end
      head_q  <= '0;
      chead_q <= '0;
      tail_q  <= '{wrap: 1'b1, idx: '0};  // list starts full
      count_q <= CW'(FL_DEPTH);
    end else begin
      spec_rat_q <= spec_rat_d;
      comm_rat_q <= comm_rat_d;
      fl_q       <= fl_d;
      head_q     <= head_d;
      chead_q    <= chead_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

`ifdef RENAME_BUSY_EN
  logic [PHYS_REGS-1:0] ready_q, ready_d;

  always_comb begin
    ready_d = ready_q;
    if (wb_valid) ready_d[wb_phys] = 1'b1;
    if (alloc)    ready_d[fl_q[head_q.idx]] = 1'b0;
    if (flush)    ready_d = '1;
    ready_d[0] = 1'b1;
    // Writeback in the same cycle as the read is bypassed.
    rs1_ready = ready_q[phys_rs1] | (wb_valid && (wb_phys == phys_rs1));
    rs2_ready = ready_q[phys_rs2] | (wb_valid && (wb_phys == phys_rs2));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ready_q <= '1;
    else       ready_q <= ready_d;
  end
`endif

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(retire_eff && (count_q == CW'(FL_DEPTH))));

endmodule

// File: tb/tb_rename_map_unit.sv
`timescale 1ns/1ps
module tb_rename_map_unit;

  logic       clk, reset;
  logic       issue_valid, issue_ready;
  logic [4:0] rd, rs1, rs2;
  logic       rd_we;
  logic [5:0] phys_rs1, phys_rs2, phys_rd, old_phys_rd;
  logic       alloc;
  logic       retire_valid, retire_we;
  logic [4:0] retire_rd;
  logic [5:0] retire_phys_rd, retire_old_phys;
  logic       flush;
  logic [5:0] free_count;
`ifdef RENAME_BUSY_EN
  logic       wb_valid;
  logic [5:0] wb_phys;
  logic       rs1_ready, rs2_ready;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  rename_map_unit dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .rd(rd), .rs1(rs1), .rs2(rs2), .rd_we(rd_we),
    .phys_rs1(phys_rs1), .phys_rs2(phys_rs2),
    .phys_rd(phys_rd), .old_phys_rd(old_phys_rd), .alloc(alloc),
    .retire_valid(retire_valid), .retire_we(retire_we), .retire_rd(retire_rd),
    .retire_phys_rd(retire_phys_rd), .retire_old_phys(retire_old_phys),
    .flush(flush),
`ifdef RENAME_BUSY_EN
    .wb_valid(wb_valid), .wb_phys(wb_phys),
    .rs1_ready(rs1_ready), .rs2_ready(rs2_ready),
`endif
    .free_count(free_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int iv, rd, rs1, rs2, we, rv, rwe, rrd, rph, rold, fl;
    int e_rdy, e_prs1, e_prs2, e_prd, e_old, e_alc, e_fc;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic idle();
    issue_valid = 0; rd = 0; rs1 = 0; rs2 = 0; rd_we = 0;
    retire_valid = 0; retire_we = 0; retire_rd = 0;
    retire_phys_rd = 0; retire_old_phys = 0; flush = 0;
`ifdef RENAME_BUSY_EN
    wb_valid = 0; wb_phys = 0;
`endif
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  // Start a new cycle: inputs are driven just after a falling edge.
  task automatic cyc();
    @(negedge clk);
    idle();
  endtask

  task automatic issue(input int r, input int s1, input int s2, input int we);
    issue_valid = 1; rd = 5'(r); rs1 = 5'(s1); rs2 = 5'(s2); rd_we = we[0];
  endtask

  task automatic retire(input int r, input int ph, input int old);
    retire_valid = 1; retire_we = 1; retire_rd = 5'(r);
    retire_phys_rd = 6'(ph); retire_old_phys = 6'(old);
  endtask

  initial begin
    reset = 1;
    idle();

    //           iv rd rs1 rs2 we rv rwe rrd rph rold fl  rdy prs1 prs2 prd old alc fc
    tbl[0]  = '{0, 0, 31, 17, 0, 0, 0,  0,  0,  0,  0,   1,  31,  17,  0,  0, 0, 32};
    tbl[1]  = '{1, 1,  2,  3, 1, 0, 0,  0,  0,  0,  0,   1,   2,   3, 32,  1, 1, 32};
    tbl[2]  = '{1, 2,  1,  0, 1, 0, 0,  0,  0,  0,  0,   1,  32,   0, 33,  2, 1, 31};
    tbl[3]  = '{1, 3,  2,  1, 1, 0, 0,  0,  0,  0,  0,   1,  33,  32, 34,  3, 1, 30};
    tbl[4]  = '{1, 4,  3,  3, 0, 0, 0,  0,  0,  0,  0,   1,  34,  34,  0,  0, 0, 29};
    tbl[5]  = '{1, 0,  0,  0, 1, 0, 0,  0,  0,  0,  0,   1,   0,   0,  0,  0, 0, 29};
    tbl[6]  = '{0, 5,  1,  0, 1, 0, 0,  0,  0,  0,  0,   1,  32,   0, 35,  5, 0, 29};
    tbl[7]  = '{1, 5,  0,  0, 1, 1, 1,  1, 32,  1,  0,   1,   0,   0, 35,  5, 1, 29};
    tbl[8]  = '{0, 0,  5,  1, 0, 0, 0,  0,  0,  0,  0,   1,  35,  32,  0,  0, 0, 29};
    tbl[9]  = '{1, 6,  0,  0, 1, 0, 0,  0,  0,  0,  1,   0,   0,   0, 36,  6, 0, 29};
    tbl[10] = '{0, 3,  1,  2, 1, 0, 0,  0,  0,  0,  0,   1,  32,   2, 33,  3, 0, 32};
    tbl[11] = '{0, 0,  5,  3, 0, 1, 1,  0, 50,  9,  0,   1,   5,   3,  0,  0, 0, 32};
    tbl[12] = '{0, 1,  0,  0, 1, 0, 0,  0,  0,  0,  0,   1,   0,   0, 33, 32, 0, 32};

    do_reset();
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      issue_valid = tbl[i].iv[0]; rd = 5'(tbl[i].rd); rs1 = 5'(tbl[i].rs1);
      rs2 = 5'(tbl[i].rs2); rd_we = tbl[i].we[0];
      retire_valid = tbl[i].rv[0]; retire_we = tbl[i].rwe[0]; retire_rd = 5'(tbl[i].rrd);
      retire_phys_rd = 6'(tbl[i].rph); retire_old_phys = 6'(tbl[i].rold);
      flush = tbl[i].fl[0];
      #1;
      chk($sformatf("vec%0d.issue_ready", i), int'(issue_ready), tbl[i].e_rdy);
      chk($sformatf("vec%0d.phys_rs1", i),    int'(phys_rs1),    tbl[i].e_prs1);
      chk($sformatf("vec%0d.phys_rs2", i),    int'(phys_rs2),    tbl[i].e_prs2);
      chk($sformatf("vec%0d.phys_rd", i),     int'(phys_rd),     tbl[i].e_prd);
      chk($sformatf("vec%0d.old_phys_rd", i), int'(old_phys_rd), tbl[i].e_old);
      chk($sformatf("vec%0d.alloc", i),       int'(alloc),       tbl[i].e_alc);
      chk($sformatf("vec%0d.free_count", i),  int'(free_count),  tbl[i].e_fc);
    end

    // Drain the whole free list, stall, then recycle one register.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      cyc(); issue(1 + (i % 31), 0, 0, 1); #1;
      chk($sformatf("drain%0d.phys_rd", i), int'(phys_rd), 32 + i);
      chk($sformatf("drain%0d.alloc", i), int'(alloc), 1);
    end
    cyc(); issue(4, 0, 0, 1); #1;
    chk("empty.free_count", int'(free_count), 0);
    chk("empty.ready_alloc", int'(issue_ready), 0);
    chk("empty.alloc", int'(alloc), 0);
    cyc(); issue(4, 0, 0, 0); #1;
    chk("empty.ready_noalloc", int'(issue_ready), 1);
    cyc(); issue(4, 0, 0, 1); retire(1, 32, 1); #1;
    chk("empty.no_bypass", int'(issue_ready), 0);
    cyc(); issue(4, 0, 0, 1); #1;
    chk("recycle.free_count", int'(free_count), 1);
    chk("recycle.ready", int'(issue_ready), 1);
    chk("recycle.phys_rd", int'(phys_rd), 1);
    chk("recycle.alloc", int'(alloc), 1);
    cyc(); #1;
    chk("recycle.after", int'(free_count), 0);

    // Flush after a commit restores committed mapping and free-list head.
    do_reset();
    cyc(); issue(5, 0, 0, 1); #1;
    chk("flushA.phys_rd0", int'(phys_rd), 32);
    cyc(); retire(5, 32, 5);
    cyc(); issue(5, 0, 0, 1); #1;
    chk("flushA.phys_rd1", int'(phys_rd), 33);
    chk("flushA.old", int'(old_phys_rd), 32);
    cyc(); flush = 1; #1;
    chk("flushA.ready", int'(issue_ready), 0);
    cyc(); rs1 = 5; rd = 5; rd_we = 1; #1;
    chk("flushA.spec5", int'(phys_rs1), 32);
    chk("flushA.next_prd", int'(phys_rd), 33);
    chk("flushA.free_count", int'(free_count), 32);

    // Flush with a same-cycle retire of rd=7 and an ignored issue.
    do_reset();
    cyc(); issue(7, 0, 0, 1); #1;
    chk("flushB.phys_rd", int'(phys_rd), 32);
    cyc(); flush = 1; retire(7, 32, 7); issue(9, 7, 0, 1); #1;
    chk("flushB.ready", int'(issue_ready), 0);
    chk("flushB.alloc", int'(alloc), 0);
    cyc(); rs1 = 7; rs2 = 9; rd = 9; rd_we = 1; #1;
    chk("flushB.spec7", int'(phys_rs1), 32);
    chk("flushB.spec9", int'(phys_rs2), 9);
    chk("flushB.next_prd", int'(phys_rd), 33);
    chk("flushB.free_count", int'(free_count), 32);

    // Asynchronous reset takes effect without a clock edge.
    do_reset();
    cyc(); issue(2, 0, 0, 1);
    cyc(); rs1 = 2; #1;
    chk("arst.before", int'(phys_rs1), 32);
    reset = 1; #1;
    chk("arst.free_count", int'(free_count), 32);
    chk("arst.spec2", int'(phys_rs1), 2);
    reset = 0;

`ifdef RENAME_BUSY_EN
    do_reset();
    cyc(); issue(1, 0, 0, 1);
    cyc(); rs1 = 1; rs2 = 2; #1;
    chk("busy.rs1_not_ready", int'(rs1_ready), 0);
    chk("busy.rs2_ready", int'(rs2_ready), 1);
    wb_valid = 1; wb_phys = 32; #1;
    chk("busy.bypass", int'(rs1_ready), 1);
    cyc(); rs1 = 1; #1;
    chk("busy.set", int'(rs1_ready), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
